// File: rtl/fpu_fclass_arbiter.sv
// Round-robin arbiter sharing one FCLASS.S classifier among NUM_REQ issue slots.
// Two-stage valid/ready pipeline returns the one-hot class word and requester id in accept order.
module fpu_fclass_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_operand,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_class,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy
);

    localparam int DATA_W = 32;

    function automatic logic [DATA_W-1:0] classify(input logic [DATA_W-1:0] x);
        logic              s;
        logic [7:0]        e;
        logic [22:0]       f;
        logic [DATA_W-1:0] c;
        s = x[31];
        e = x[30:23];
        f = x[22:0];
        c = '0;
        if (e == 8'hFF) begin
            if (f == '0)
                c[s ? 0 : 7] = 1'b1;
            else if (f[22])
                c[9] = 1'b1;
            else
                c[8] = 1'b1;
        end else if (e == 8'h00) begin
            if (f == '0)
                c[s ? 3 : 4] = 1'b1;
            else
                c[s ? 2 : 5] = 1'b1;
        end else begin
            c[s ? 1 : 6] = 1'b1;
        end
        return c;
    endfunction

    logic [ID_W-1:0]    r_rr_ptr;
    logic               r_vld_p1;
    logic [DATA_W-1:0]  r_op_p1;
    logic [ID_W-1:0]    r_id_p1;
    logic               r_vld_p2;
    logic [DATA_W-1:0]  r_class_p2;
    logic [ID_W-1:0]    r_id_p2;

    logic               w_s1_ready;
    logic               w_s2_ready;
    logic               w_gnt_found;
    logic [ID_W-1:0]    w_gnt_id;
    logic [ID_W-1:0]    w_idx;
    logic [NUM_REQ-1:0] w_gnt_onehot;
    logic               w_accept;
    logic [DATA_W-1:0]  w_win_operand;
    logic [ID_W-1:0]    w_next_ptr;

    // Arbitration: first valid requester at or after r_rr_ptr, wrapping
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        w_idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_gnt_found && req_valid[w_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = w_idx;
            end
        end
    end

    assign w_s2_ready    = ~r_vld_p2 | rsp_ready;
    assign w_s1_ready    = ~r_vld_p1 | w_s2_ready;
    assign w_gnt_onehot  = NUM_REQ'(1) << w_gnt_id;
    assign w_accept      = w_gnt_found & w_s1_ready;
    assign req_ready     = w_accept ? w_gnt_onehot : '0;
    assign w_win_operand = req_operand[DATA_W*w_gnt_id +: DATA_W];
    assign w_next_ptr    = (w_gnt_id == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_id + 1'b1;

    // Control and output-stage state; S2 data is cleared so rsp_* read zero after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_vld_p1   <= 1'b0;
            r_vld_p2   <= 1'b0;
            r_class_p2 <= '0;
            r_id_p2    <= '0;
        end else begin
            if (w_accept)
                r_rr_ptr <= w_next_ptr;
            if (w_accept)
                r_vld_p1 <= 1'b1;
            else if (w_s2_ready)
                r_vld_p1 <= 1'b0;
            // S1 -> S2: classify on the way into the output stage
            if (w_s2_ready) begin
                r_vld_p2 <= r_vld_p1;
                if (r_vld_p1) begin
                    r_class_p2 <= classify(r_op_p1);
                    r_id_p2    <= r_id_p1;
                end
            end
        end
    end

    // Accept -> S1: operand payload needs no reset, it is qualified by r_vld_p1
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op_p1 <= w_win_operand;
            r_id_p1 <= w_gnt_id;
        end
    end

    assign rsp_valid = r_vld_p2;
    assign rsp_class = r_class_p2;
    assign rsp_id    = r_id_p2;
    assign busy      = r_vld_p1 | r_vld_p2;

endmodule

// File: tb/tb_fpu_fclass_arbiter.sv
// Directed and random self-checking bench for fpu_fclass_arbiter with an in-order scoreboard.
module tb_fpu_fclass_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int T6_OPS  = 10000;
    localparam int T6_MAX  = 60000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_operand;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_class;
    logic [ID_W-1:0]       rsp_id;
    logic                  busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_acc   = 0;
    int          n_rsp   = 0;
    int          sb_id[$];
    logic [31:0] sb_op[$];
    logic        hold_prev = 1'b0;
    logic [31:0] prev_class;
    logic [ID_W-1:0] prev_id;
    logic [NUM_REQ-1:0] lacc;

    always #5 clk = ~clk;

    fpu_fclass_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_operand(req_operand), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_class(rsp_class), .rsp_id(rsp_id), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_class(input logic [31:0] x);
        logic        neg;
        logic [7:0]  e;
        logic [22:0] f;
        int          idx;
        neg = x[31];
        e   = x[30:23];
        f   = x[22:0];
        if (e == 8'hFF && f != 0)   idx = f[22] ? 9 : 8;
        else if (e == 8'hFF)        idx = neg ? 0 : 7;
        else if (e == 0 && f == 0)  idx = neg ? 3 : 4;
        else if (e == 0)            idx = neg ? 2 : 5;
        else                        idx = neg ? 1 : 6;
        return 32'(1) << idx;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 7))
            0: v[30:23] = 8'hFF;
            1: v[30:23] = 8'h00;
            2: begin v[30:23] = 8'hFF; v[22:0] = '0; end
            3: v[30:0] = '0;
            default: ;
        endcase
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] v);
        req_operand[32*i +: 32] = v;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        step();
        rst_n = 1'b1;
    endtask

    // Scoreboard and output-stability monitor, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_id.delete();
                sb_op.delete();
                n_acc = 0;
                n_rsp = 0;
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_valid", 32'(rsp_valid), 1);
                    check("hold_class", rsp_class, prev_class);
                    check("hold_id", 32'(rsp_id), 32'(prev_id));
                end
                check("ready_onehot", 32'($countones(req_ready) > 1), 0);
                check("ready_without_valid", 32'(req_ready & ~req_valid), 0);
                if (rsp_valid && rsp_ready) begin
                    if (sb_id.size() == 0) begin
                        check("rsp_unexpected", 32'(rsp_valid), 0);
                    end else begin
                        check("sb_class", rsp_class, ref_class(sb_op[0]));
                        check("sb_id", 32'(rsp_id), 32'(sb_id[0]));
                        void'(sb_id.pop_front());
                        void'(sb_op.pop_front());
                        n_rsp++;
                    end
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        sb_id.push_back(i);
                        sb_op.push_back(req_operand[32*i +: 32]);
                        n_acc++;
                    end
                end
                hold_prev  = rsp_valid & ~rsp_ready;
                prev_class = rsp_class;
                prev_id    = rsp_id;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] t1_op [3];
        logic [31:0] t1_cls[3];
        logic [31:0] t2_op [4];
        logic [31:0] t2_cls[4];
        logic [3:0]  t4_gnt[3];
        int          start;
        int          cyc;

        t1_op  = '{32'h7FC00000, 32'hFF800000, 32'h00000001};
        t1_cls = '{32'h200, 32'h001, 32'h020};
        t2_op  = '{32'h80000000, 32'h3F800000, 32'h7F800001, 32'h7F800000};
        t2_cls = '{32'h008, 32'h040, 32'h100, 32'h080};
        t4_gnt = '{4'b1000, 4'b0010, 4'b1000};

        rst_n       = 1'b0;
        req_valid   = '0;
        req_operand = '0;
        rsp_ready   = 1'b0;
        #2;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_class", rsp_class, 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_busy", 32'(busy), 0);
        step();
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        step();
        check("idle_ready", 32'(req_ready), 0);

        // T1: single ops on requester 0, two-cycle latency
        for (int k = 0; k < 3; k++) begin
            set_op(0, t1_op[k]);
            req_valid = 4'b0001;
            #1;
            check("t1_ready", 32'(req_ready), 1);
            step();
            req_valid = '0;
            check("t1_busy", 32'(busy), 1);
            check("t1_rsp_early", 32'(rsp_valid), 0);
            step();
            check("t1_rsp_valid", 32'(rsp_valid), 1);
            check("t1_class", rsp_class, t1_cls[k]);
            check("t1_id", 32'(rsp_id), 0);
            step();
            check("t1_drained", 32'(busy), 0);
        end

        // T2: all requesters valid, round-robin from 0 at full throughput
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, t2_op[i]);
        req_valid = 4'hF;
        for (int k = 0; k < 7; k++) begin
            if (k == 5) req_valid = '0;
            #1;
            if (k < 5) check("t2_grant", 32'(req_ready), 32'(1) << (k % 4));
            if (k >= 2) begin
                check("t2_rsp_valid", 32'(rsp_valid), 1);
                check("t2_class", rsp_class, t2_cls[(k-2) % 4]);
                check("t2_id", 32'(rsp_id), (k-2) % 4);
            end
            step();
        end
        check("t2_drained", 32'(busy), 0);

        // T3: backpressure with requests streaming (rr_ptr is 1 here)
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        for (int k = 0; k < 9; k++) begin
            if (k == 5) rsp_ready = 1'b1;
            if (k == 8) req_valid = '0;
            #1;
            if (k == 0) check("t3_grant0", 32'(req_ready), 32'h2);
            if (k == 1) check("t3_grant1", 32'(req_ready), 32'h4);
            if (k >= 2 && k <= 4) begin
                check("t3_stall_ready", 32'(req_ready), 0);
                check("t3_hold_valid", 32'(rsp_valid), 1);
                check("t3_hold_id", 32'(rsp_id), 1);
                check("t3_hold_class", rsp_class, 32'h040);
                check("t3_busy", 32'(busy), 1);
            end
            if (k == 5) check("t3_release_grant", 32'(req_ready), 32'h8);
            step();
        end
        step(); step(); step();
        check("t3_count", n_rsp, n_acc);
        check("t3_drained", 32'(busy), 0);

        // T4: only requesters 3 and 1 valid, starting from rr_ptr=2
        do_reset();
        rsp_ready = 1'b1;
        set_op(1, 32'h3F800000);
        req_valid = 4'b0010;
        #1;
        check("t4_setup", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        step(); step();
        set_op(3, 32'hFF800000);
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_grant", 32'(req_ready), 32'(t4_gnt[k]));
            step();
        end
        req_valid = '0;
        step(); step(); step();

        // T5: asynchronous reset with both stages full
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        step(); step();
        check("t5_full_busy", 32'(busy), 1);
        check("t5_full_valid", 32'(rsp_valid), 1);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        check("t5_rst_valid", 32'(rsp_valid), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_class", rsp_class, 0);
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        step();
        check("t5_no_stale", 32'(rsp_valid), 0);
        check("t5_idle_busy", 32'(busy), 0);
        req_valid = 4'hF;
        #1;
        check("t5_first_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        step(); step(); step();

        // T6: random traffic; losers hold valid/operand until accepted
        start = n_rsp;
        cyc   = 0;
        while ((n_rsp - start) < T6_OPS && cyc < T6_MAX) begin
            @(negedge clk);
            lacc = req_valid & req_ready;
            step();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (lacc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 3) != 0) begin
                    req_valid[i] = 1'b1;
                    set_op(i, rand_op());
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        check("t6_in_time", 32'(cyc < T6_MAX), 1);
        req_valid = '0;
        rsp_ready = 1'b1;
        step(); step(); step(); step();
        check("t6_sb_empty", sb_id.size(), 0);
        check("t6_count", n_rsp, n_acc);
        check("t6_drained", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
